// File: rtl/irq_sync_ctrl.sv
// irq_sync_ctrl: per-channel synchroniser, debounce filter, level/edge pending latch and mask for the CPU irq vector.
// Define IRQ_SYNC_LOST_EN to add the sticky IRQ_LOST overrun flags.
module irq_sync_ctrl #(
  parameter int NUM_IRQ       = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IRQIN,
  input  logic [NUM_IRQ-1:0] IRQ_EDGE,
  input  logic [NUM_IRQ-1:0] IRQ_MASK,
  input  logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic [NUM_IRQ-1:0] IRQ_PEND,
  output logic [NUM_IRQ-1:0] IRQOUT
`ifdef IRQ_SYNC_LOST_EN
  ,
  output logic [NUM_IRQ-1:0] IRQ_LOST
`endif
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_IRQ-1:0] filt_s;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] pend_r;

  for (genvar n = 0; n < NUM_IRQ; n++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   filt_r;
    logic                   samp_s;
    logic                   differ_s;
    logic                   expire_s;

    assign samp_s   = sync_r[SYNC_STAGES-1];
    assign differ_s = samp_s ^ filt_r;
    assign expire_s = differ_s & (cnt_r == CNT_MAX);

    // Synchroniser shift chain for the asynchronous input line.
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], IRQIN[n]};
      end
    end

    // Debounce: filtered level only moves after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_r  <= {CW{1'b0}};
        filt_r <= 1'b0;
      end else if (!differ_s) begin
        cnt_r  <= {CW{1'b0}};
        filt_r <= filt_r;
      end else if (expire_s) begin
        cnt_r  <= {CW{1'b0}};
        filt_r <= samp_s;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        filt_r <= filt_r;
      end
    end

    assign filt_s[n] = filt_r;
    assign rise_s[n] = expire_s & samp_s;
  end

  // Edge-mode pending latch: a rise beats a same-cycle ACK; level mode holds it clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_r <= {NUM_IRQ{1'b0}};
    end else begin
      pend_r <= IRQ_EDGE & (rise_s | (pend_r & ~IRQ_ACK));
    end
  end

  assign IRQ_PEND = (IRQ_EDGE & pend_r) | (~IRQ_EDGE & filt_s);
  assign IRQOUT   = IRQ_PEND & ~IRQ_MASK;

`ifdef IRQ_SYNC_LOST_EN
  logic [NUM_IRQ-1:0] lost_r;

  // Sticky overrun flag: a new edge event arrived while the previous one was still pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lost_r <= {NUM_IRQ{1'b0}};
    end else begin
      lost_r <= (IRQ_EDGE & rise_s & pend_r & ~IRQ_ACK) | (lost_r & ~IRQ_ACK);
    end
  end

  assign IRQ_LOST = lost_r;
`endif

endmodule

// File: tb/tb_irq_sync_ctrl.sv
// Scoreboard bench for irq_sync_ctrl: directed vectors push expected outputs, a negedge monitor pops and compares.
// A second instance with FILTER_CYCLES=1 shares the stimulus for the glitch-pass case.
module tb_irq_sync_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irqin;
  logic [7:0] irq_edge;
  logic [7:0] irq_mask;
  logic [7:0] irq_ack;
  logic [7:0] pend0, out0, pend1, out1;
`ifdef IRQ_SYNC_LOST_EN
  logic [7:0] lost0, lost1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      nm;
    logic [7:0] chk, ep, eo;
    logic [7:0] chk1, ep1;
    logic [7:0] chkl, el;
  } exp_t;

  exp_t sb[$];

  irq_sync_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2), .FILTER_CYCLES(2)) u_dut (
    .CLK(clk), .RST(rst), .IRQIN(irqin), .IRQ_EDGE(irq_edge), .IRQ_MASK(irq_mask),
    .IRQ_ACK(irq_ack), .IRQ_PEND(pend0), .IRQOUT(out0)
`ifdef IRQ_SYNC_LOST_EN
    , .IRQ_LOST(lost0)
`endif
  );

  irq_sync_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2), .FILTER_CYCLES(1)) u_dut_f1 (
    .CLK(clk), .RST(rst), .IRQIN(irqin), .IRQ_EDGE(irq_edge), .IRQ_MASK(irq_mask),
    .IRQ_ACK(irq_ack), .IRQ_PEND(pend1), .IRQOUT(out1)
`ifdef IRQ_SYNC_LOST_EN
    , .IRQ_LOST(lost1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are already driven; record what the outputs must show before the next edge, then advance.
  task automatic step(input string nm, input logic [7:0] chk, input logic [7:0] ep, input logic [7:0] eo,
                      input logic [7:0] chk1 = 8'h00, input logic [7:0] ep1 = 8'h00,
                      input logic [7:0] chkl = 8'h00, input logic [7:0] el = 8'h00);
    exp_t e;
    e.nm = nm; e.chk = chk; e.ep = ep; e.eo = eo;
    e.chk1 = chk1; e.ep1 = ep1; e.chkl = chkl; e.el = el;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 8'h00, 8'h00, 8'h00);
  endtask

  // Monitor: one scoreboard entry per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk != 8'h00) begin
        n_tests++;
        if (((pend0 & e.chk) != (e.ep & e.chk)) || ((out0 & e.chk) != (e.eo & e.chk))) begin
          n_fail++;
          $display("FAIL %s: pend=%h out=%h, required pend=%h out=%h (bits %h)",
                   e.nm, pend0 & e.chk, out0 & e.chk, e.ep & e.chk, e.eo & e.chk, e.chk);
        end
      end
      if (e.chk1 != 8'h00) begin
        n_tests++;
        if ((pend1 & e.chk1) != (e.ep1 & e.chk1)) begin
          n_fail++;
          $display("FAIL %s_f1: pend=%h, required %h (bits %h)",
                   e.nm, pend1 & e.chk1, e.ep1 & e.chk1, e.chk1);
        end
      end
`ifdef IRQ_SYNC_LOST_EN
      if (e.chkl != 8'h00) begin
        n_tests++;
        if ((lost0 & e.chkl) != (e.el & e.chkl)) begin
          n_fail++;
          $display("FAIL %s_lost: lost=%h, required %h (bits %h)",
                   e.nm, lost0 & e.chkl, e.el & e.chkl, e.chkl);
        end
      end
`endif
    end
  end

  initial begin
    rst      = 1'b1;
    irqin    = 8'h00;
    irq_edge = 8'h1C;
    irq_mask = 8'h00;
    irq_ack  = 8'h00;
    @(posedge clk);
    #1;
    step("reset", 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
    rst = 1'b0;
    idle(2);

    // 1: level channel 0, four edges to assert and four to deassert.
    irqin[0] = 1'b1;
    step("t1_pre", 8'h01, 8'h00, 8'h00);
    step("t1_e0", 8'h01, 8'h00, 8'h00);
    step("t1_e1", 8'h01, 8'h00, 8'h00);
    step("t1_e2", 8'h01, 8'h00, 8'h00);
    step("t1_e3", 8'h01, 8'h01, 8'h01);
    irqin[0] = 1'b0;
    step("t1_hold", 8'h01, 8'h01, 8'h01);
    step("t1_d0", 8'h01, 8'h01, 8'h01);
    step("t1_d1", 8'h01, 8'h01, 8'h01);
    step("t1_d2", 8'h01, 8'h01, 8'h01);
    step("t1_d3", 8'h01, 8'h00, 8'h00);
    idle(2);

    // 2: one-cycle glitch on channel 1 is dropped at FILTER_CYCLES=2, passes for one cycle at 1.
    irqin[1] = 1'b1;
    step("t2_pre", 8'h02, 8'h00, 8'h00, 8'h02, 8'h00);
    irqin[1] = 1'b0;
    step("t2_e0", 8'h02, 8'h00, 8'h00, 8'h02, 8'h00);
    step("t2_e1", 8'h02, 8'h00, 8'h00, 8'h02, 8'h00);
    step("t2_e2", 8'h02, 8'h00, 8'h00, 8'h02, 8'h02);
    step("t2_e3", 8'h02, 8'h00, 8'h00, 8'h02, 8'h00);
    step("t2_e4", 8'h02, 8'h00, 8'h00, 8'h02, 8'h00);
    idle(2);

    // 3: edge channel 2 latches a two-cycle pulse, holds, clears on ACK.
    irqin[2] = 1'b1;
    step("t3_pre", 8'h04, 8'h00, 8'h00);
    step("t3_e0", 8'h04, 8'h00, 8'h00);
    irqin[2] = 1'b0;
    step("t3_e1", 8'h04, 8'h00, 8'h00);
    step("t3_e2", 8'h04, 8'h00, 8'h00);
    step("t3_e3", 8'h04, 8'h04, 8'h04);
    for (int i = 0; i < 20; i++) step("t3_hold", 8'h04, 8'h04, 8'h04);
    irq_ack[2] = 1'b1;
    step("t3_ack", 8'h04, 8'h04, 8'h04);
    irq_ack[2] = 1'b0;
    step("t3_clr", 8'h04, 8'h00, 8'h00);
    idle(2);

    // 3b: ACK on the strobe edge loses to the set.
    irqin[2] = 1'b1;
    step("t3b_pre", 8'h04, 8'h00, 8'h00);
    step("t3b_e0", 8'h04, 8'h00, 8'h00);
    irqin[2] = 1'b0;
    step("t3b_e1", 8'h04, 8'h00, 8'h00);
    irq_ack[2] = 1'b1;
    step("t3b_e2", 8'h04, 8'h00, 8'h00);
    irq_ack[2] = 1'b0;
    step("t3b_setwins", 8'h04, 8'h04, 8'h04);
    step("t3b_hold", 8'h04, 8'h04, 8'h04);
    irq_ack[2] = 1'b1;
    step("t3b_ack", 8'h04, 8'h04, 8'h04);
    irq_ack[2] = 1'b0;
    step("t3b_clr", 8'h04, 8'h00, 8'h00);
    idle(3);

    // 3c: switching to level mode drops the pending bit; switching back does not restore it.
    irqin[2] = 1'b1;
    step("t3c_pre", 8'h04, 8'h00, 8'h00);
    step("t3c_e0", 8'h04, 8'h00, 8'h00);
    irqin[2] = 1'b0;
    step("t3c_e1", 8'h04, 8'h00, 8'h00);
    step("t3c_e2", 8'h04, 8'h00, 8'h00);
    step("t3c_e3", 8'h04, 8'h04, 8'h04);
    step("t3c_e4", 8'h04, 8'h04, 8'h04);
    step("t3c_e5", 8'h04, 8'h04, 8'h04);
    step("t3c_e6", 8'h04, 8'h04, 8'h04);
    irq_edge[2] = 1'b0;
    step("t3c_lvl", 8'h04, 8'h00, 8'h00);
    irq_edge[2] = 1'b1;
    step("t3c_back", 8'h04, 8'h00, 8'h00);
    idle(2);

    // 4: masked edge channel 3 latches but stays off IRQOUT until unmasked.
    irq_mask[3] = 1'b1;
    irqin[3] = 1'b1;
    step("t4_pre", 8'h08, 8'h00, 8'h00);
    step("t4_e0", 8'h08, 8'h00, 8'h00);
    irqin[3] = 1'b0;
    step("t4_e1", 8'h08, 8'h00, 8'h00);
    step("t4_e2", 8'h08, 8'h00, 8'h00);
    step("t4_masked", 8'h08, 8'h08, 8'h00);
    step("t4_masked2", 8'h08, 8'h08, 8'h00);
    irq_mask[3] = 1'b0;
    step("t4_unmask", 8'h08, 8'h08, 8'h08);
    irq_ack[3] = 1'b1;
    step("t4_ack", 8'h08, 8'h08, 8'h08);
    irq_ack[3] = 1'b0;
    step("t4_clr", 8'h08, 8'h00, 8'h00);
    idle(3);

    // 5: reset lands while the counter is mid-qualification; a held input needs four fresh edges.
    irqin[0] = 1'b1;
    step("t5_pre", 8'h01, 8'h00, 8'h00);
    step("t5_e0", 8'h01, 8'h00, 8'h00);
    step("t5_e1", 8'h01, 8'h00, 8'h00);
    rst = 1'b1;
    step("t5_e2", 8'h01, 8'h00, 8'h00);
    rst = 1'b0;
    step("t5_rst", 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
    step("t5_r0", 8'h01, 8'h00, 8'h00);
    step("t5_r1", 8'h01, 8'h00, 8'h00);
    step("t5_r2", 8'h01, 8'h00, 8'h00);
    step("t5_r3", 8'h01, 8'h01, 8'h01);
    irqin[0] = 1'b0;
    idle(6);

    // 6: two edge events on channel 4 without ACK flag an overrun; one ACK clears both.
    irqin[4] = 1'b1;
    step("t6_pre", 8'h10, 8'h00, 8'h00);
    step("t6_e0", 8'h10, 8'h00, 8'h00);
    irqin[4] = 1'b0;
    step("t6_e1", 8'h10, 8'h00, 8'h00);
    step("t6_e2", 8'h10, 8'h00, 8'h00);
    step("t6_ev1", 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00);
    idle(3);
    irqin[4] = 1'b1;
    step("t6_pre2", 8'h10, 8'h10, 8'h10);
    step("t6_f0", 8'h10, 8'h10, 8'h10);
    irqin[4] = 1'b0;
    step("t6_f1", 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00);
    step("t6_f2", 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00);
    step("t6_ev2", 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10);
    irq_ack[4] = 1'b1;
    step("t6_ack", 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10);
    irq_ack[4] = 1'b0;
    step("t6_clr", 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00);
    idle(2);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
